// File: rtl/flow_pkg.sv
// Shared types for the LED flow path: speed levels, direction encoding and step periods.
// The LED shifter imports this too, so both sides agree on what dir_out means.
package flow_pkg;

  localparam int unsigned NUM_SPEEDS = 4;

  typedef logic [1:0] speed_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  // Speed 3 is the fastest; every step down doubles the period.
  function automatic int unsigned period_of(input speed_t s, input int unsigned base);
    return base << (int'(NUM_SPEEDS) - 1 - int'(s));
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton input path: 2-flop synchronizer, stability counter and a
// single-cycle pulse on each debounced press (releases are silent).
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic btn_in,
  output logic press_out
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          level_dly_q, level_dly_d;
  logic          press_q, press_d;

  always_comb begin
    sync_d      = {sync_q[0], btn_in};
    cnt_d       = '0;
    level_d     = level_q;
    level_dly_d = level_q;
    // Rising edge is taken from the registered level, so the pulse trails the flip by one cycle.
    press_d     = level_q & ~level_dly_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == LAST) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      press_q     <= press_d;
    end
  end

  assign press_out = press_q;

endmodule

// File: rtl/flow_tick_ctrl.sv
// Button-driven run state (speed, direction, pause) and the step strobe generator
// that paces the LED flow shifter.
module flow_tick_ctrl
  import flow_pkg::*;
#(
  parameter int unsigned BASE_DIV        = 2400,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       btn_speed_in,
  input  logic       btn_dir_in,
  input  logic       btn_pause_in,
  output logic       step_out,
  output logic       dir_out,
  output logic       paused_out,
  output logic [1:0] speed_out
);

  localparam int unsigned CNT_W = $clog2(8 * BASE_DIV);

  function automatic logic [CNT_W-1:0] reload_of(input speed_t s);
    return CNT_W'(period_of(s, BASE_DIV) - 1);
  endfunction

  logic speed_press, dir_press, pause_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_speed (
    .clk_in(clk_in), .rst_n(rst_n), .btn_in(btn_speed_in), .press_out(speed_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dir (
    .clk_in(clk_in), .rst_n(rst_n), .btn_in(btn_dir_in), .press_out(dir_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
    .clk_in(clk_in), .rst_n(rst_n), .btn_in(btn_pause_in), .press_out(pause_press)
  );

  speed_t           speed_q, speed_d;
  dir_t             dir_q, dir_d;
  logic             paused_q, paused_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             run;

  always_comb begin
    speed_d  = speed_q;
    dir_d    = dir_q;
    paused_d = paused_q;
    cnt_d    = cnt_q;
    step_d   = 1'b0;

    if (speed_press) speed_d = speed_q + speed_t'(1);
    if (dir_press)   dir_d   = (dir_q == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
    if (pause_press) paused_d = ~paused_q;

    // A pause press freezes the counter on its own edge, swallowing a coincident terminal step.
    run = ~paused_q & ~pause_press;
    if (run) begin
      if (cnt_q == '0) begin
        step_d = 1'b1;
        cnt_d  = reload_of(speed_d);
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    if (speed_press) cnt_d = reload_of(speed_d);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      speed_q  <= '0;
      dir_q    <= DIR_LEFT;
      paused_q <= 1'b0;
      cnt_q    <= reload_of(speed_t'(0));
      step_q   <= 1'b0;
    end else begin
      speed_q  <= speed_d;
      dir_q    <= dir_d;
      paused_q <= paused_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
    end
  end

  assign step_out   = step_q;
  assign dir_out    = dir_q;
  assign paused_out = paused_q;
  assign speed_out  = speed_q;

endmodule

// File: tb/tb_flow_tick_ctrl.sv
// Scoreboard bench for flow_tick_ctrl with BASE_DIV=4, DEBOUNCE_CYCLES=3: directed
// button timelines push expected step edges and state changes; a monitor pops them.
module tb_flow_tick_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       btn_speed_in, btn_dir_in, btn_pause_in;
  logic       step_out, dir_out, paused_out;
  logic [1:0] speed_out;

  flow_tick_ctrl #(.BASE_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
    .clk_in(clk_in), .rst_n(rst_n),
    .btn_speed_in(btn_speed_in), .btn_dir_in(btn_dir_in), .btn_pause_in(btn_pause_in),
    .step_out(step_out), .dir_out(dir_out), .paused_out(paused_out), .speed_out(speed_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [1:0] spd;
    logic       dir;
    logic       pau;
  } st_t;

  int   exp_step_q[$];
  st_t  exp_st_q[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  bit   prev_step = 1'b0;
  logic [3:0] last_st = 4'h0;

  // Monitor: pops an expectation whenever the DUT strobes a step or changes state.
  always @(negedge clk_in) begin
    if (mon_en) begin
      if (step_out === 1'b1) begin
        total++;
        if (exp_step_q.size() == 0) begin
          bad++;
          $display("FAIL step_unexpected cyc=%0d", cyc);
        end else begin
          int e;
          e = exp_step_q.pop_front();
          if (e != cyc) begin
            bad++;
            $display("FAIL step_time got cyc=%0d exp cyc=%0d", cyc, e);
          end
        end
        total++;
        if (prev_step) begin
          bad++;
          $display("FAIL step_back2back cyc=%0d got two high cycles exp one", cyc);
        end
      end
      prev_step = (step_out === 1'b1);
      if ({speed_out, dir_out, paused_out} !== last_st) begin
        total++;
        if (exp_st_q.size() == 0) begin
          bad++;
          $display("FAIL state_unexpected cyc=%0d got spd=%0d dir=%0b pau=%0b", cyc, speed_out,
                   dir_out, paused_out);
        end else begin
          st_t e;
          e = exp_st_q.pop_front();
          if (e.c != cyc || e.spd !== speed_out || e.dir !== dir_out || e.pau !== paused_out) begin
            bad++;
            $display("FAIL state_change got cyc=%0d spd=%0d dir=%0b pau=%0b exp cyc=%0d spd=%0d dir=%0b pau=%0b",
                     cyc, speed_out, dir_out, paused_out, e.c, e.spd, e.dir, e.pau);
          end
        end
        last_st = {speed_out, dir_out, paused_out};
      end
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic exp_st(input int c, input int s, input bit d, input bit p);
    st_t e;
    e.c = c; e.spd = 2'(s); e.dir = d; e.pau = p;
    exp_st_q.push_back(e);
  endtask

  task automatic exp_steps(input int a, input int b, input int c);
    if (a > 0) exp_step_q.push_back(a);
    if (b > 0) exp_step_q.push_back(b);
    if (c > 0) exp_step_q.push_back(c);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    btn_speed_in = 1'b0; btn_dir_in = 1'b0; btn_pause_in = 1'b0;

    // Idle at speed 0: release edge 4, period 32.
    exp_steps(35, 67, 99);
    wait_to(1);
    chk("rst_step", int'(step_out), 0);
    chk("rst_dir", int'(dir_out), 0);
    chk("rst_paused", int'(paused_out), 0);
    chk("rst_speed", int'(speed_out), 0);
    mon_en = 1'b1;
    wait_to(3);  rst_n = 1'b1;
    wait_to(110); rst_n = 1'b0;
    wait_to(111); rst_n = 1'b1;

    // Held speed button: one press, speed 1 at +6 from first sample, period 16.
    exp_st(119, 1, 0, 0);
    exp_steps(135, 151, 167);
    exp_st(176, 0, 0, 0);
    wait_to(112); btn_speed_in = 1'b1;
    wait_to(170); btn_speed_in = 1'b0;
    wait_to(175); rst_n = 1'b0;
    wait_to(176); rst_n = 1'b1;

    // Dir: 2-cycle glitch ignored, clean press toggles, cadence untouched.
    exp_st(197, 0, 1, 0);
    exp_steps(208, 240, 272);
    exp_st(281, 0, 0, 0);
    wait_to(180); btn_dir_in = 1'b1;
    wait_to(182); btn_dir_in = 1'b0;
    wait_to(190); btn_dir_in = 1'b1;
    wait_to(200); btn_dir_in = 1'b0;
    wait_to(280); rst_n = 1'b0;
    wait_to(281); rst_n = 1'b1;

    // Pause with count 10 held; unpause at 337 gives the step 11 cycles later.
    exp_st(303, 0, 0, 1);
    exp_st(337, 0, 0, 0);
    exp_steps(348, 380, 0);
    wait_to(296); btn_pause_in = 1'b1;
    wait_to(306); btn_pause_in = 1'b0;
    wait_to(330); btn_pause_in = 1'b1;
    wait_to(340); btn_pause_in = 1'b0;
    wait_to(385); rst_n = 1'b0;
    wait_to(386); rst_n = 1'b1;

    // Speed 1,2,3,0; the last press lands on a terminal count at 486.
    exp_st(397, 1, 0, 0);
    exp_st(450, 2, 0, 0);
    exp_st(470, 3, 0, 0);
    exp_st(486, 0, 0, 0);
    exp_steps(413, 429, 445);
    exp_steps(458, 466, 474);
    exp_steps(478, 482, 486);
    exp_steps(518, 550, 0);
    wait_to(390); btn_speed_in = 1'b1;
    wait_to(394); btn_speed_in = 1'b0;
    wait_to(443); btn_speed_in = 1'b1;
    wait_to(447); btn_speed_in = 1'b0;
    wait_to(463); btn_speed_in = 1'b1;
    wait_to(467); btn_speed_in = 1'b0;
    wait_to(479); btn_speed_in = 1'b1;
    wait_to(483); btn_speed_in = 1'b0;

    // Build speed=2, dir=1, paused=1, then reset during a debounce.
    exp_st(567, 1, 1, 0);
    exp_st(577, 2, 1, 0);
    exp_steps(585, 0, 0);
    exp_st(587, 2, 1, 1);
    exp_st(593, 0, 0, 0);
    exp_steps(625, 0, 0);
    wait_to(560); btn_speed_in = 1'b1; btn_dir_in = 1'b1;
    wait_to(564); btn_speed_in = 1'b0; btn_dir_in = 1'b0;
    wait_to(570); btn_speed_in = 1'b1;
    wait_to(574); btn_speed_in = 1'b0;
    wait_to(580); btn_pause_in = 1'b1;
    wait_to(584); btn_pause_in = 1'b0;
    wait_to(590); btn_speed_in = 1'b1;
    wait_to(592); rst_n = 1'b0; btn_speed_in = 1'b0;
    wait_to(593); rst_n = 1'b1;

    wait_to(640);
    mon_en = 1'b0;
    chk("steps_left", exp_step_q.size(), 0);
    chk("states_left", exp_st_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
